// File: rtl/seven_segment_display_driver_if.sv
// seven_segment_display_driver_if: load/shadow inputs and display outputs of the seven-segment driver
// load, value, blank_mask, blink_mask, lz_en : master -> driver
// seg_static, seg_mux, dig_sel, blink_phase : driver -> master
interface seven_segment_display_driver_if #(parameter int NUM_DIGITS = 6);
  logic load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic lz_en;
  logic [7*NUM_DIGITS-1:0] seg_static;
  logic [6:0] seg_mux;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic blink_phase;
  modport master(output load, value, blank_mask, blink_mask, lz_en,
                 input seg_static, seg_mux, dig_sel, blink_phase);
  modport slave(input load, value, blank_mask, blink_mask, lz_en,
                output seg_static, seg_mux, dig_sel, blink_phase);
endinterface

// File: rtl/seven_segment_display_driver.sv
// seven_segment_display_driver: hex display driver with static and multiplexed outputs
// clk, reset (async active-high) plain ports; bus (slave) carries load/value/masks/lz_en in,
// seg_static/seg_mux/dig_sel/blink_phase out.
module seven_segment_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input logic clk,
  input logic reset,
  seven_segment_display_driver_if.slave bus
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic AL = ACTIVE_LOW != 0;
  localparam logic [6:0] DARK = {7{AL}};
  // active-low g..a patterns for 0..F
  localparam logic [6:0] ENC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic {SLOT, DEAD} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d, blink_q, blink_d, dark;
  logic lz_q, lz_d;
  logic [7*NUM_DIGITS-1:0] seg_static_q, seg_static_d;
  logic [6:0] seg_mux_q, seg_mux_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d, one_hot;
  logic scan_wrap, blink_wrap;
  assign val_d = bus.load ? bus.value : val_q;
  assign blank_d = bus.load ? bus.blank_mask : blank_q;
  assign blink_d = bus.load ? bus.blink_mask : blink_q;
  assign lz_d = bus.load ? bus.lz_en : lz_q;
  assign scan_wrap = scnt_q == SW'(SCAN_DIV - 1);
  assign blink_wrap = bcnt_q == BW'(BLINK_DIV - 1);
  assign bcnt_d = blink_wrap ? '0 : bcnt_q + 1'b1;
  assign phase_d = phase_q ^ blink_wrap;
  always_comb begin
    state_d = state_q;
    scnt_d = scnt_q;
    idx_d = idx_q;
    if (state_q == SLOT) begin
      scnt_d = scan_wrap ? '0 : scnt_q + 1'b1;
      state_d = scan_wrap ? DEAD : SLOT;
    end else begin
      state_d = SLOT;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end
  // Outputs are computed from next-state values so a load shows up one clock later.
  always_comb begin
    logic zero_up;
    zero_up = 1'b1;
    dark = '0;
    seg_static_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_up = zero_up & (val_d[4*i +: 4] == 4'd0);
      dark[i] = blank_d[i] | (blink_d[i] & phase_d) | (lz_d & (i > 0) & zero_up);
      seg_static_d[7*i +: 7] = dark[i] ? DARK : ENC[val_d[4*i +: 4]] ^ {7{~AL}};
    end
    seg_mux_d = state_d == DEAD ? DARK : seg_static_d[7*int'(idx_d) +: 7];
    one_hot = state_d == SLOT ? NUM_DIGITS'(1) << idx_d : '0;
    dig_sel_d = one_hot ^ {NUM_DIGITS{AL}};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT;
      scnt_q <= '0;
      bcnt_q <= '0;
      idx_q <= '0;
      phase_q <= 1'b0;
      val_q <= '0;
      blank_q <= '0;
      blink_q <= '0;
      lz_q <= 1'b0;
      seg_static_q <= {NUM_DIGITS{DARK}};
      seg_mux_q <= DARK;
      dig_sel_q <= {NUM_DIGITS{AL}};
    end else begin
      state_q <= state_d;
      scnt_q <= scnt_d;
      bcnt_q <= bcnt_d;
      idx_q <= idx_d;
      phase_q <= phase_d;
      val_q <= val_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      lz_q <= lz_d;
      seg_static_q <= seg_static_d;
      seg_mux_q <= seg_mux_d;
      dig_sel_q <= dig_sel_d;
    end
  end
  assign bus.seg_static = seg_static_q;
  assign bus.seg_mux = seg_mux_q;
  assign bus.dig_sel = dig_sel_q;
  assign bus.blink_phase = phase_q;
endmodule

// File: tb/tb_seven_segment_display_driver.sv
// tb_seven_segment_display_driver: self-checking bench for the seven-segment driver
module tb_seven_segment_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  seven_segment_display_driver_if #(.NUM_DIGITS(6)) bus();
  seven_segment_display_driver_if #(.NUM_DIGITS(3)) bus_hi();
  seven_segment_display_driver #(.NUM_DIGITS(6), .SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW(1))
    dut (.clk(clk), .reset(rst), .bus(bus));
  seven_segment_display_driver #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW(0))
    dut_hi (.clk(clk), .reset(rst), .bus(bus_hi));
  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [23:0] cv;
  logic [5:0] cbl, cbk;
  logic clz;
  logic [11:0] hv;
  logic [2:0] hbl;
  logic [41:0] sb[$];
  always @(posedge clk or posedge rst) n <= rst ? 0 : n + 1;
  function automatic logic [6:0] enc_ref(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010; 4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction
  function automatic logic ph_at(input int k);
    return ((k / 8) % 2) == 1;
  endfunction
  function automatic logic [41:0] exp_static(input logic [23:0] v, input logic [5:0] bl, input logic [5:0] bk,
                                            input logic lz, input logic ph);
    logic [41:0] r;
    logic dk;
    for (int i = 0; i < 6; i++) begin
      dk = bl[i] || (bk[i] && ph) || (lz && i > 0 && (v >> (4 * i)) == 24'd0);
      r[7*i +: 7] = dk ? 7'h7F : enc_ref(v[4*i +: 4]);
    end
    return r;
  endfunction
  function automatic logic [20:0] exp_hi(input logic [11:0] v, input logic [2:0] bl);
    logic [20:0] r;
    for (int i = 0; i < 3; i++) r[7*i +: 7] = bl[i] ? 7'h00 : ~enc_ref(v[4*i +: 4]);
    return r;
  endfunction
  task automatic drive(input logic [23:0] v, input logic [5:0] bl, input logic [5:0] bk, input logic lz);
    logic [41:0] e;
    bus.load = 1'b1; bus.value = v; bus.blank_mask = bl; bus.blink_mask = bk; bus.lz_en = lz;
    cv = v; cbl = bl; cbk = bk; clz = lz;
    sb.push_back(exp_static(v, bl, bk, lz, ph_at(n + 1)));
    @(posedge clk); #1;
    bus.load = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.seg_static !== e) begin
      errors++;
      $display("FAIL load_seg_static value=%h got=%h exp=%h", v, bus.seg_static, e);
    end
  endtask
  task automatic drive_hi(input logic [11:0] v, input logic [2:0] bl);
    logic [20:0] e;
    bus_hi.load = 1'b1; bus_hi.value = v; bus_hi.blank_mask = bl; bus_hi.blink_mask = '0; bus_hi.lz_en = 1'b0;
    hv = v; hbl = bl;
    sb.push_back({21'd0, exp_hi(v, bl)});
    @(posedge clk); #1;
    bus_hi.load = 1'b0;
    e = sb.pop_front()[20:0];
    checks++;
    if (bus_hi.seg_static !== e) begin
      errors++;
      $display("FAIL hi_seg_static value=%h got=%h exp=%h", v, bus_hi.seg_static, e);
    end
  endtask
  task automatic check_dark(input string tag);
    checks++;
    if (bus.seg_static !== {42{1'b1}} || bus.seg_mux !== 7'h7F || bus.dig_sel !== 6'h3F || bus.blink_phase !== 1'b0) begin
      errors++;
      $display("FAIL %s got seg=%h mux=%h sel=%b ph=%b exp all dark/off ph=0", tag, bus.seg_static, bus.seg_mux, bus.dig_sel, bus.blink_phase);
    end
    checks++;
    if (bus_hi.seg_static !== 21'd0 || bus_hi.dig_sel !== 3'b000) begin
      errors++;
      $display("FAIL %s_hi got seg=%h sel=%b exp 0/000", tag, bus_hi.seg_static, bus_hi.dig_sel);
    end
  endtask
  task automatic check_first_after_reset(input string tag);
    checks++;
    if (bus.dig_sel !== 6'b111110 || bus.seg_static !== {6{7'h40}} || bus.blink_phase !== 1'b0) begin
      errors++;
      $display("FAIL %s got sel=%b seg=%h ph=%b exp 111110/%h/0", tag, bus.dig_sel, bus.seg_static, bus.blink_phase, {6{7'h40}});
    end
    checks++;
    if (bus_hi.dig_sel !== 3'b001) begin
      errors++;
      $display("FAIL %s_hi got sel=%b exp 001", tag, bus_hi.dig_sel);
    end
  endtask
  task automatic test_reset;
    #1 rst = 1'b1;
    #2 check_dark("reset_dark");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_first_after_reset("reset_release");
  endtask
  task automatic test_load;
    drive(24'h0123AF, '0, '0, 1'b0);
    drive(24'hFEDCBA, '0, '0, 1'b0);
    drive(24'h987654, 6'b100001, '0, 1'b0);
  endtask
  task automatic test_lz;
    drive(24'h000040, '0, '0, 1'b1);
    drive(24'h000000, '0, '0, 1'b1);
    drive(24'h100000, '0, '0, 1'b1);
  endtask
  task automatic test_scan;
    int q, idx;
    logic [5:0] es;
    logic [6:0] em;
    logic [2:0] hs;
    logic [6:0] hm;
    logic [41:0] st;
    logic [20:0] sh;
    drive(24'h0123AF, '0, '0, 1'b0);
    drive_hi(12'h5A7, '0);
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      q = n % 5;
      idx = (n / 5) % 6;
      st = exp_static(cv, cbl, cbk, clz, ph_at(n));
      es = q == 4 ? 6'h3F : ~(6'b000001 << idx);
      em = q == 4 ? 7'h7F : st[7*idx +: 7];
      checks++;
      if (bus.dig_sel !== es || bus.seg_mux !== em) begin
        errors++;
        $display("FAIL scan n=%0d got sel=%b mux=%b exp sel=%b mux=%b", n, bus.dig_sel, bus.seg_mux, es, em);
      end
      idx = (n / 5) % 3;
      sh = exp_hi(hv, hbl);
      hs = q == 4 ? 3'b000 : 3'b001 << idx;
      hm = q == 4 ? 7'h00 : sh[7*idx +: 7];
      checks++;
      if (bus_hi.dig_sel !== hs || bus_hi.seg_mux !== hm) begin
        errors++;
        $display("FAIL scan_hi n=%0d got sel=%b mux=%b exp sel=%b mux=%b", n, bus_hi.dig_sel, bus_hi.seg_mux, hs, hm);
      end
    end
  endtask
  task automatic test_blink;
    logic [41:0] e;
    int c;
    drive(24'h123456, '0, 6'b000010, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      e = exp_static(cv, cbl, cbk, clz, ph_at(n));
      checks++;
      if (bus.blink_phase !== ph_at(n) || bus.seg_static !== e) begin
        errors++;
        $display("FAIL blink n=%0d got ph=%b seg=%h exp ph=%b seg=%h", n, bus.blink_phase, bus.seg_static, ph_at(n), e);
      end
    end
    c = 0;
    while (!(ph_at(n) && ph_at(n + 1)) && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c >= 40) begin
      errors++;
      $display("FAIL blink_wait got timeout exp dark phase");
    end
    drive(24'h654321, '0, 6'b000010, 1'b0);
    checks++;
    if (bus.blink_phase !== 1'b1 || bus.seg_static[13:7] !== 7'h7F) begin
      errors++;
      $display("FAIL blink_load got ph=%b dig1=%b exp 1/1111111", bus.blink_phase, bus.seg_static[13:7]);
    end
  endtask
  task automatic test_reset_mid;
    int c;
    c = 0;
    while (!(n % 5 >= 1 && n % 5 <= 3 && (n / 5) % 6 == 2 && ph_at(n)) && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c >= 300 || bus.dig_sel !== 6'b111011 || bus.blink_phase !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got sel=%b ph=%b exp 111011/1", bus.dig_sel, bus.blink_phase);
    end
    #2 rst = 1'b1;
    #1 check_dark("reset_mid_dark");
    @(posedge clk); #1;
    rst = 1'b0;
    cv = '0; cbl = '0; cbk = '0; clz = 1'b0; hv = '0; hbl = '0;
    @(posedge clk); #1;
    check_first_after_reset("reset_mid_release");
  endtask
  task automatic test_active_high;
    drive_hi(12'h008, 3'b000);
    checks++;
    if (bus_hi.seg_static[6:0] !== 7'b1111111) begin
      errors++;
      $display("FAIL hi_eight got=%b exp=1111111", bus_hi.seg_static[6:0]);
    end
    drive_hi(12'h008, 3'b001);
    checks++;
    if (bus_hi.seg_static[6:0] !== 7'b0000000) begin
      errors++;
      $display("FAIL hi_blank got=%b exp=0000000", bus_hi.seg_static[6:0]);
    end
  endtask
  initial begin
    bus.load = 1'b0; bus.value = '0; bus.blank_mask = '0; bus.blink_mask = '0; bus.lz_en = 1'b0;
    bus_hi.load = 1'b0; bus_hi.value = '0; bus_hi.blank_mask = '0; bus_hi.blink_mask = '0; bus_hi.lz_en = 1'b0;
    cv = '0; cbl = '0; cbk = '0; clz = 1'b0; hv = '0; hbl = '0;
    test_reset;
    test_load;
    test_lz;
    test_scan;
    test_blink;
    test_reset_mid;
    test_active_high;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule
